multicycle_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM. Sequences the shared datapath (one memory, one ALU, IR, ALUOut, MDR) through FETCH/DECODE/EXEC/MEM/WB.
//  It supports the same instruction set as the single-cycle decoder: R-type incl. jr, beq, bne, addi, slti, sltiu, andi, ori, xori, lui, lw, sw, j, jal.

---
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: 3 cycles for branch/jump/illegal, 4 for R/I/sw, 5 for lw.
// Memory accesses in FETCH, MEM_RD and MEM_WR hold their state until mem_ready.
module multicycle_ctrl #(
   parameter logic [5:0] JR_FUNCT = 6'd8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_write_ne,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       jal,
   output logic       illegal_op,
   output logic       retire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_WB_MEM   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_I     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_JR       = 4'd13,
      S_ILLEGAL  = 4'd14
   } state_e;

   state_e state_q, state_d;

   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               6'd0:                     state_d = (funct == JR_FUNCT) ? S_JR : S_EXEC_R;
               6'd4, 6'd5:               state_d = S_BRANCH;
               6'd2:                     state_d = S_JUMP;
               6'd3:                     state_d = S_JAL;
               6'd35, 6'd43:             state_d = S_MEM_ADDR;
               6'd8, 6'd10, 6'd11, 6'd12,
               6'd13, 6'd14, 6'd15:      state_d = S_EXEC_I;
               default:                  state_d = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == 6'd43) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         default:    state_d = S_FETCH;
      endcase
   end

   // Every output, including the debug state, is held at zero while reset_n is low.
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_write_ne   = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 3'b000;
      alu_op        = 3'b000;
      reg_dst       = 2'b00;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      jal           = 1'b0;
      illegal_op    = 1'b0;
      retire        = 1'b0;
      state         = reset_n ? state_q : 4'd0;
      if (reset_n) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 3'b001;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 3'b101;
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 3'b010;
            end
            S_MEM_RD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            S_WB_MEM: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               retire     = 1'b1;
            end
            S_MEM_WR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
               retire    = mem_ready;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b110;
            end
            S_WB_R: begin
               reg_dst   = 2'b01;
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               case (opcode)
                  6'd8:         alu_src_b = 3'b010;
                  6'd10, 6'd11: begin alu_src_b = 3'b010; alu_op = 3'b101; end
                  6'd12:        begin alu_src_b = 3'b011; alu_op = 3'b010; end
                  6'd13:        begin alu_src_b = 3'b011; alu_op = 3'b011; end
                  6'd14:        begin alu_src_b = 3'b011; alu_op = 3'b100; end
                  6'd15:        alu_src_b = 3'b100;
                  default:      alu_src_b = 3'b000;
               endcase
            end
            S_WB_I: begin
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 3'b001;
               pc_source     = 2'b01;
               pc_write_cond = (opcode == 6'd4);
               pc_write_ne   = (opcode == 6'd5);
               retire        = 1'b1;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               retire    = 1'b1;
            end
            S_JAL: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               reg_dst   = 2'b10;
               reg_write = 1'b1;
               jal       = 1'b1;
               retire    = 1'b1;
            end
            S_JR: begin
               pc_write  = 1'b1;
               pc_source = 2'b11;
               retire    = 1'b1;
            end
            S_ILLEGAL: begin
               illegal_op = 1'b1;
               retire     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes its expected state and
// control word; the monitor pops and compares on the following falling edge.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_ne;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       jal;
      logic       illegal_op;
      logic       retire;
   } ctl_t;

   typedef struct packed {
      logic [3:0] st;
      ctl_t       c;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n, mem_ready;
   logic [5:0] opcode, funct;
   ctl_t       act;
   logic [3:0] state;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   exp_t sb_q[$];

   multicycle_ctrl #(.JR_FUNCT(6'd8)) dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .mem_read(act.mem_read), .mem_write(act.mem_write), .iord(act.iord),
      .ir_write(act.ir_write), .pc_write(act.pc_write), .pc_write_cond(act.pc_write_cond),
      .pc_write_ne(act.pc_write_ne), .pc_source(act.pc_source), .alu_src_a(act.alu_src_a),
      .alu_src_b(act.alu_src_b), .alu_op(act.alu_op), .reg_dst(act.reg_dst),
      .mem_to_reg(act.mem_to_reg), .reg_write(act.reg_write), .jal(act.jal),
      .illegal_op(act.illegal_op), .retire(act.retire), .state(state)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Expected control word for a given state, held opcode and mem_ready.
   function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
      ctl_t e = '0;
      case (st)
         4'd0:  begin e.mem_read = 1; e.alu_src_b = 3'b001; e.ir_write = rdy; e.pc_write = rdy; end
         4'd1:  e.alu_src_b = 3'b101;
         4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 3'b010; end
         4'd3:  begin e.iord = 1; e.mem_read = 1; end
         4'd4:  begin e.mem_to_reg = 1; e.reg_write = 1; e.retire = 1; end
         4'd5:  begin e.iord = 1; e.mem_write = 1; e.retire = rdy; end
         4'd6:  begin e.alu_src_a = 1; e.alu_op = 3'b110; end
         4'd7:  begin e.reg_dst = 2'b01; e.reg_write = 1; e.retire = 1; end
         4'd8: begin
            e.alu_src_a = 1;
            if (op == 6'd8)                   e.alu_src_b = 3'b010;
            if (op == 6'd10 || op == 6'd11) begin e.alu_src_b = 3'b010; e.alu_op = 3'b101; end
            if (op == 6'd12) begin e.alu_src_b = 3'b011; e.alu_op = 3'b010; end
            if (op == 6'd13) begin e.alu_src_b = 3'b011; e.alu_op = 3'b011; end
            if (op == 6'd14) begin e.alu_src_b = 3'b011; e.alu_op = 3'b100; end
            if (op == 6'd15)                  e.alu_src_b = 3'b100;
         end
         4'd9:  begin e.reg_write = 1; e.retire = 1; end
         4'd10: begin
            e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_source = 2'b01; e.retire = 1;
            e.pc_write_cond = (op == 6'd4); e.pc_write_ne = (op == 6'd5);
         end
         4'd11: begin e.pc_write = 1; e.pc_source = 2'b10; e.retire = 1; end
         4'd12: begin
            e.pc_write = 1; e.pc_source = 2'b10; e.reg_dst = 2'b10;
            e.reg_write = 1; e.jal = 1; e.retire = 1;
         end
         4'd13: begin e.pc_write = 1; e.pc_source = 2'b11; e.retire = 1; end
         4'd14: begin e.illegal_op = 1; e.retire = 1; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic step(input logic rn, input logic rdy, input logic [5:0] op,
                       input logic [5:0] fn, input logic [3:0] st);
      exp_t e;
      reset_n   = rn;
      mem_ready = rdy;
      opcode    = op;
      funct     = fn;
      e.st = rn ? st : 4'd0;
      e.c  = rn ? exp_ctl(st, op, rdy) : '0;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Walks one instruction from FETCH to its retiring state; mem_ready is random where ignored.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fetch_wait, input int mem_wait);
      logic [3:0] path[$];
      for (int i = 0; i < fetch_wait; i++) step(1'b1, 1'b0, 6'($urandom), 6'($urandom), 4'd0);
      step(1'b1, 1'b1, 6'($urandom), 6'($urandom), 4'd0);
      step(1'b1, 1'($urandom), op, fn, 4'd1);
      case (op)
         6'd0:         path = (fn == 6'd8) ? '{4'd13} : '{4'd6, 4'd7};
         6'd4, 6'd5:   path = '{4'd10};
         6'd2:         path = '{4'd11};
         6'd3:         path = '{4'd12};
         6'd35, 6'd43: path = '{4'd2};
         6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: path = '{4'd8, 4'd9};
         default:      path = '{4'd14};
      endcase
      foreach (path[i]) step(1'b1, 1'($urandom), op, fn, path[i]);
      if (op == 6'd35 || op == 6'd43) begin
         for (int i = 0; i < mem_wait; i++)
            step(1'b1, 1'b0, op, fn, (op == 6'd35) ? 4'd3 : 4'd5);
         step(1'b1, 1'b1, op, fn, (op == 6'd35) ? 4'd3 : 4'd5);
         if (op == 6'd35) step(1'b1, 1'($urandom), op, fn, 4'd4);
      end
   endtask

   always @(negedge clock) begin
      cyc++;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check_val($sformatf("cyc%0d state", cyc), 32'(state), 32'(e.st));
         check_val($sformatf("cyc%0d ctl", cyc), 32'(act), 32'(e.c));
      end
   end

   initial begin
      reset_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'd0, 6'd0, 4'd0);

      run_instr(6'd8,  6'd0,  0, 0);
      run_instr(6'd35, 6'd0,  0, 2);
      run_instr(6'd4,  6'd0,  1, 0);
      run_instr(6'd5,  6'd0,  0, 0);
      run_instr(6'd3,  6'd0,  0, 0);
      run_instr(6'd0,  6'd8,  0, 0);
      run_instr(6'd0,  6'd32, 2, 0);
      run_instr(6'd63, 6'd0,  0, 0);
      run_instr(6'd43, 6'd0,  0, 1);
      run_instr(6'd2,  6'd0,  0, 0);
      for (int i = 10; i <= 15; i++) run_instr(6'(i), 6'd0, 0, 0);
      run_instr(6'd1,  6'd0,  0, 0);
      run_instr(6'd35, 6'd0,  1, 0);

      // Store stalled in MEM_WR, then reset: write request must drop immediately.
      step(1'b1, 1'b1, 6'd43, 6'd0, 4'd0);
      step(1'b1, 1'b0, 6'd43, 6'd0, 4'd1);
      step(1'b1, 1'b0, 6'd43, 6'd0, 4'd2);
      step(1'b1, 1'b0, 6'd43, 6'd0, 4'd5);
      step(1'b0, 1'b0, 6'd43, 6'd0, 4'd5);
      step(1'b1, 1'b0, 6'd43, 6'd0, 4'd0);
      run_instr(6'd8, 6'd0, 0, 0);

      @(negedge clock);
      #1;
      check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
